// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline hazard, branch-flush and data-memory wait controller
module pipeline_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic [4:0]       rd_ex,
    input  logic             RuWr_ex,
    input  logic [1:0]       RUDataWrSrc_ex,
    input  logic [1:0]       RUDataWrSrc_me,
    input  logic             DMWr_me,
    input  logic             br_taken_ex,
    input  logic             dm_ready,
    output logic             en_pc,
    output logic             en_ifid,
    output logic             en_idex,
    output logic             en_exme,
    output logic             en_mewb,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WC_W = $clog2(TIMEOUT) + 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TIMEOUT - 1);
    localparam logic [WC_W-1:0] WAIT_ONE  = {{(WC_W-1){1'b0}}, 1'b1};

    typedef enum logic {RUN, MEMWAIT} state_t;

    state_t          state;
    logic [WC_W-1:0] wait_cnt;
    logic            dm_req_me;
    logic            load_use;
    logic            frozen;

    assign dm_req_me = DMWr_me | (RUDataWrSrc_me == 2'b01);
    assign load_use  = RuWr_ex & (RUDataWrSrc_ex == 2'b01) & (rd_ex != 5'd0)
                     & ((rd_ex == rs1_id) | (rd_ex == rs2_id));

    always_comb begin
        frozen     = 1'b0;
        en_pc      = 1'b0;
        en_ifid    = 1'b0;
        en_idex    = 1'b0;
        en_exme    = 1'b0;
        en_mewb    = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        if (!rst) begin
            if (state == RUN)
                frozen = dm_req_me & ~dm_ready;
            else
                frozen = ~dm_ready & (wait_cnt < WAIT_LAST);
            // Frozen cycles hold every register; pending branch/load-use is acted on at release.
            if (!frozen) begin
                en_exme = 1'b1;
                en_mewb = 1'b1;
                en_idex = 1'b1;
                if (br_taken_ex) begin
                    en_pc      = 1'b1;
                    en_ifid    = 1'b1;
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                end else if (load_use) begin
                    flush_idex = 1'b1;
                end else begin
                    en_pc   = 1'b1;
                    en_ifid = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (!en_pc && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
            case (state)
                RUN: begin
                    if (dm_req_me && !dm_ready) begin
                        state    <= MEMWAIT;
                        wait_cnt <= WAIT_ONE;
                    end
                end
                MEMWAIT: begin
                    if (dm_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt >= WAIT_LAST) begin
                        mem_err  <= 1'b1;
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;

    localparam logic [6:0] O_ZERO = 7'b0000000;
    localparam logic [6:0] O_RUN  = 7'b1111100;
    localparam logic [6:0] O_BR   = 7'b1111111;
    localparam logic [6:0] O_LU   = 7'b0011101;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [4:0]       rs1_id = '0, rs2_id = '0, rd_ex = '0;
    logic             RuWr_ex = 1'b0;
    logic [1:0]       RUDataWrSrc_ex = '0, RUDataWrSrc_me = '0;
    logic             DMWr_me = 1'b0, br_taken_ex = 1'b0, dm_ready = 1'b0;
    logic             en_pc, en_ifid, en_idex, en_exme, en_mewb, flush_ifid, flush_idex;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [6:0]       outs;

    int tests = 0;
    int failed = 0;

    assign outs = {en_pc, en_ifid, en_idex, en_exme, en_mewb, flush_ifid, flush_idex};

    always #5 clk = ~clk;

    pipeline_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_ex(rd_ex),
        .RuWr_ex(RuWr_ex), .RUDataWrSrc_ex(RUDataWrSrc_ex), .RUDataWrSrc_me(RUDataWrSrc_me),
        .DMWr_me(DMWr_me), .br_taken_ex(br_taken_ex), .dm_ready(dm_ready),
        .en_pc(en_pc), .en_ifid(en_ifid), .en_idex(en_idex), .en_exme(en_exme), .en_mewb(en_mewb),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs1_id = '0; rs2_id = '0; rd_ex = '0; RuWr_ex = 1'b0;
        RUDataWrSrc_ex = '0; RUDataWrSrc_me = '0;
        DMWr_me = 1'b0; br_taken_ex = 1'b0; dm_ready = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
        rd_ex = rd; rs1_id = r1; rs2_id = r2; RuWr_ex = 1'b1; RUDataWrSrc_ex = 2'b01;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_inputs();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_load_use(5'd5, 5'd5, 5'd5);
        br_taken_ex = 1'b1; DMWr_me = 1'b1; dm_ready = 1'b1;
        #1;
        tests++; if (outs !== O_ZERO) begin failed++; $display("FAIL reset_outs got %b want %b", outs, O_ZERO); end
        step();
        tests++; if (stall_cnt !== 4'd0) begin failed++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
        tests++; if (mem_err !== 1'b0) begin failed++; $display("FAIL reset_memerr got %b want 0", mem_err); end
        rst = 1'b0;
        clear_inputs();
        #1;
        tests++; if (outs !== O_RUN) begin failed++; $display("FAIL reset_release got %b want %b", outs, O_RUN); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use(5'd5, 5'd1, 5'd5);
        #1;
        tests++; if (outs !== O_LU) begin failed++; $display("FAIL lu_rs2 got %b want %b", outs, O_LU); end
        step();
        clear_inputs();
        #1;
        tests++; if (stall_cnt !== 4'd1) begin failed++; $display("FAIL lu_rs2_cnt got %0d want 1", stall_cnt); end
        tests++; if (outs !== O_RUN) begin failed++; $display("FAIL lu_after got %b want %b", outs, O_RUN); end
        step();
        set_load_use(5'd7, 5'd7, 5'd2);
        #1;
        tests++; if (outs !== O_LU) begin failed++; $display("FAIL lu_rs1 got %b want %b", outs, O_LU); end
        step();
        tests++; if (stall_cnt !== 4'd2) begin failed++; $display("FAIL lu_rs1_cnt got %0d want 2", stall_cnt); end
        set_load_use(5'd0, 5'd1, 5'd0);
        #1;
        tests++; if (outs !== O_RUN) begin failed++; $display("FAIL lu_rd0 got %b want %b", outs, O_RUN); end
        set_load_use(5'd5, 5'd1, 5'd5); RuWr_ex = 1'b0;
        #1;
        tests++; if (outs !== O_RUN) begin failed++; $display("FAIL lu_nowr got %b want %b", outs, O_RUN); end
        set_load_use(5'd5, 5'd1, 5'd5); RUDataWrSrc_ex = 2'b00;
        #1;
        tests++; if (outs !== O_RUN) begin failed++; $display("FAIL lu_alusrc got %b want %b", outs, O_RUN); end
        step();
        tests++; if (stall_cnt !== 4'd2) begin failed++; $display("FAIL lu_nostall_cnt got %0d want 2", stall_cnt); end
        clear_inputs();
    endtask

    task automatic test_branch();
        do_reset();
        set_load_use(5'd5, 5'd1, 5'd5);
        br_taken_ex = 1'b1;
        #1;
        tests++; if (outs !== O_BR) begin failed++; $display("FAIL br_over_lu got %b want %b", outs, O_BR); end
        step();
        tests++; if (stall_cnt !== 4'd0) begin failed++; $display("FAIL br_cnt got %0d want 0", stall_cnt); end
        clear_inputs();
    endtask

    task automatic test_mem_wait();
        do_reset();
        DMWr_me = 1'b1; br_taken_ex = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (outs !== O_ZERO) begin failed++; $display("FAIL memwait_frozen%0d got %b want %b", i, outs, O_ZERO); end
            step();
        end
        dm_ready = 1'b1;
        #1;
        tests++; if (outs !== O_BR) begin failed++; $display("FAIL memwait_release got %b want %b", outs, O_BR); end
        step();
        tests++; if (stall_cnt !== 4'd3) begin failed++; $display("FAIL memwait_cnt got %0d want 3", stall_cnt); end
        tests++; if (mem_err !== 1'b0) begin failed++; $display("FAIL memwait_err got %b want 0", mem_err); end
        clear_inputs();
        RUDataWrSrc_me = 2'b01; dm_ready = 1'b1;
        #1;
        tests++; if (outs !== O_RUN) begin failed++; $display("FAIL zero_wait got %b want %b", outs, O_RUN); end
        step();
        clear_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        for (int t = 0; t < 2; t++) begin
            DMWr_me = 1'b1; dm_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
                #1;
                tests++; if (outs !== O_ZERO) begin failed++; $display("FAIL to%0d_frozen%0d got %b want %b", t, i, outs, O_ZERO); end
                step();
            end
            #1;
            tests++; if (outs !== O_RUN) begin failed++; $display("FAIL to%0d_release got %b want %b", t, outs, O_RUN); end
            tests++; if (mem_err !== (t == 1)) begin failed++; $display("FAIL to%0d_err_before got %b want %b", t, mem_err, (t == 1)); end
            step();
            tests++; if (mem_err !== 1'b1) begin failed++; $display("FAIL to%0d_err got %b want 1", t, mem_err); end
            DMWr_me = 1'b0;
            step();
        end
        tests++; if (stall_cnt !== 4'd6) begin failed++; $display("FAIL to_cnt got %0d want 6", stall_cnt); end
        do_reset();
        tests++; if (mem_err !== 1'b0) begin failed++; $display("FAIL to_err_cleared got %b want 0", mem_err); end
    endtask

    task automatic test_reset_memwait();
        do_reset();
        DMWr_me = 1'b1;
        step();
        step();
        tests++; if (stall_cnt !== 4'd2) begin failed++; $display("FAIL rmw_pre_cnt got %0d want 2", stall_cnt); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if (outs !== O_ZERO) begin failed++; $display("FAIL rmw_outs got %b want %b", outs, O_ZERO); end
        tests++; if (stall_cnt !== 4'd0) begin failed++; $display("FAIL rmw_cnt got %0d want 0", stall_cnt); end
        step();
        rst = 1'b0;
        DMWr_me = 1'b0;
        #1;
        tests++; if (outs !== O_RUN) begin failed++; $display("FAIL rmw_run got %b want %b", outs, O_RUN); end
        step();
        tests++; if (mem_err !== 1'b0) begin failed++; $display("FAIL rmw_err got %b want 0", mem_err); end
    endtask

    task automatic test_saturate();
        do_reset();
        set_load_use(5'd9, 5'd9, 5'd9);
        for (int i = 0; i < 20; i++) step();
        tests++; if (stall_cnt !== 4'hF) begin failed++; $display("FAIL sat_cnt got %0d want 15", stall_cnt); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_reset_memwait();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, max data-memory wait cycles before abort (range 2..255).
REQ-002 Parameter CNT_W, default 16, width of stall performance counter.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 rs1_id, rs2_id  in  5 each  source registers of instruction in ID.
REQ-006 rd_ex  in  5  destination register of instruction in EX.
REQ-007 RuWr_ex  in  1  EX instruction writes register file.
REQ-008 RUDataWrSrc_ex, RUDataWrSrc_me  in  2 each  write-back source; 2'b01 = data-memory read.
REQ-009 DMWr_me  in  1  ME instruction writes data memory.
REQ-010 br_taken_ex  in  1  branch/jump resolved taken in EX.
REQ-011 dm_ready  in  1  data memory completes current ME access this cycle.
REQ-012 en_pc, en_ifid, en_idex, en_exme, en_mewb  out  1 each  load enables for PC and pipeline registers.
REQ-013 flush_ifid, flush_idex  out  1 each  load NOP/zero controls into that register on next edge.
REQ-014 mem_err  out  1  sticky data-memory timeout flag.
REQ-015 stall_cnt  out  CNT_W  saturating count of cycles with en_pc=0.

Function
REQ-016 dm_req_me = DMWr_me | (RUDataWrSrc_me==2'b01).
REQ-017 load_use = RuWr_ex & (RUDataWrSrc_ex==2'b01) & rd_ex!=0 & (rd_ex==rs1_id | rd_ex==rs2_id).
REQ-018 FSM states RUN, MEMWAIT; outputs combinational from state and inputs.
REQ-019 RUN, dm_req_me & !dm_ready: all five enables 0, both flushes 0; next state MEMWAIT, wait counter loads 1.
REQ-020 RUN, dm_req_me & dm_ready (zero-wait): no memory stall; evaluate REQ-021/022.
REQ-021 RUN, no memory stall, br_taken_ex: all enables 1, flush_ifid=1, flush_idex=1 (branch wins over load_use).
REQ-022 RUN, no memory stall, no branch, load_use: en_pc=0, en_ifid=0, en_idex=1 with flush_idex=1 (one bubble), en_exme=1, en_mewb=1.
REQ-023 RUN, none of the above: all enables 1, flushes 0.
REQ-024 MEMWAIT, !dm_ready and wait counter < TIMEOUT-1: all enables 0, flushes 0, counter increments.
REQ-025 MEMWAIT, dm_ready: outputs per REQ-021..023 evaluated on current inputs (pending branch/load_use honoured), next state RUN.
REQ-026 MEMWAIT, !dm_ready and counter == TIMEOUT-1: mem_err set, outputs per REQ-021..023 (access abandoned), next state RUN.
REQ-027 Frozen cycles (REQ-019/024) never flush; branch and load-use inputs held by frozen registers and acted on at release.
REQ-028 mem_err stays 1 until reset; further timeouts have no extra effect.
REQ-029 stall_cnt increments by 1 each cycle en_pc=0, saturates at all-ones, never wraps.
REQ-030 Wait counter width ceil(log2(TIMEOUT))+1; cleared on RUN entry.

Reset
REQ-031 rst=1 forces immediately: state RUN, wait counter 0, mem_err 0, stall_cnt 0.
REQ-032 While rst=1: all enables 0, flushes 0, regardless of inputs.
REQ-033 Reset asserted in MEMWAIT aborts the wait with no mem_err; after release, first edge evaluates in RUN.

Verification
REQ-034 rd_ex=5, RuWr_ex=1, RUDataWrSrc_ex=01, rs2_id=5 -> one cycle en_pc=0, en_ifid=0, flush_idex=1; stall_cnt=1.
REQ-035 Same as REQ-034 with rd_ex=0 -> no stall, all enables 1.
REQ-036 load_use and br_taken_ex same cycle -> flush_ifid=1, flush_idex=1, en_pc=1, stall_cnt unchanged.
REQ-037 DMWr_me=1, dm_ready low 3 cycles then high -> enables 0 for 3 cycles, 1 on 4th, stall_cnt=3, mem_err=0.
REQ-038 TIMEOUT=4, dm_req_me=1, dm_ready stuck 0 -> enables 0 for 3 cycles, release on 4th, mem_err=1 until rst.
REQ-039 rst pulsed during MEMWAIT -> outputs 0 immediately, stall_cnt=0, mem_err=0, RUN after release.
